// File: rtl/alu_pkt_former.sv
// Packet former for the ALU framer: buffers framed words in a 64x32 data FIFO
// and emits each frame as header / payload / checksum trailer on valid/ready.
module alu_pkt_former (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic [31:0] frame_data,
  input  logic        pkt_ready,
  output logic        pkt_valid,
  output logic [31:0] pkt_data,
  output logic        pkt_sop,
  output logic        pkt_eop,
  output logic        buf_afull,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;

  logic [31:0] dmem [64];
  logic [5:0]  dwr_ptr, drd_ptr;
  logic [6:0]  dcnt;

  logic [36:0] qmem [4];
  logic [1:0]  qwr_ptr, qrd_ptr;
  logic [2:0]  qcnt;

  logic        cap_active, cap_drop;
  logic [4:0]  cap_len, len_nxt;
  logic [31:0] cap_sum, sum_nxt;
  logic        cap_start, cap_admit, dwr_en, desc_push;
  logic [36:0] desc_word;

  state_t      state, state_nxt;
  logic [4:0]  out_len, pay_cnt;
  logic [31:0] out_sum;
  logic        xfer, dread, desc_pop;

  // Admission needs room for a full 31-word frame plus a descriptor slot.
  assign cap_start = frame && !cap_active;
  assign cap_admit = (dcnt <= 7'd33) && (qcnt != 3'd4);
  assign len_nxt   = cap_start ? 5'd1 : cap_len + 5'd1;
  assign sum_nxt   = cap_start ? frame_data : cap_sum + frame_data;
  assign dwr_en    = frame && (cap_start ? cap_admit : !cap_drop);
  assign desc_push = (dwr_en && len_nxt == 5'd31) || (!frame && cap_active && !cap_drop);
  assign desc_word = frame ? {len_nxt, sum_nxt} : {cap_len, cap_sum};

  assign xfer     = pkt_valid && pkt_ready;
  assign dread    = (state == PAY) && xfer;
  assign desc_pop = (state == IDLE) && (qcnt != 3'd0);

  assign buf_afull = (dcnt >= 7'd33) || (qcnt >= 3'd3);

  // NOTE: storage arrays carry no reset; occupancy is governed by the reset pointers and counts.
  always_ff @(posedge clk) begin
    if (dwr_en)    dmem[dwr_ptr] <= frame_data;
    if (desc_push) qmem[qwr_ptr] <= desc_word;
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_active <= 1'b0;
      cap_drop   <= 1'b0;
      cap_len    <= '0;
      cap_sum    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (frame) begin
        cap_len    <= len_nxt;
        cap_sum    <= sum_nxt;
        cap_active <= (len_nxt != 5'd31);
        if (cap_start) cap_drop <= !cap_admit;
      end else begin
        cap_active <= 1'b0;
      end
      if (cap_start && !cap_admit && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwr_ptr <= '0;
      drd_ptr <= '0;
      dcnt    <= '0;
      qwr_ptr <= '0;
      qrd_ptr <= '0;
      qcnt    <= '0;
    end else begin
      if (dwr_en)    dwr_ptr <= dwr_ptr + 6'd1;
      if (dread)     drd_ptr <= drd_ptr + 6'd1;
      if (desc_push) qwr_ptr <= qwr_ptr + 2'd1;
      if (desc_pop)  qrd_ptr <= qrd_ptr + 2'd1;
      case ({dwr_en, dread})
        2'b10:   dcnt <= dcnt + 7'd1;
        2'b01:   dcnt <= dcnt - 7'd1;
        default: dcnt <= dcnt;
      endcase
      case ({desc_push, desc_pop})
        2'b10:   qcnt <= qcnt + 3'd1;
        2'b01:   qcnt <= qcnt - 3'd1;
        default: qcnt <= qcnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out_len <= '0;
      out_sum <= '0;
      pay_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (desc_pop) begin
        {out_len, out_sum} <= qmem[qrd_ptr];
        pay_cnt            <= 5'd1;
      end else if (dread) begin
        pay_cnt <= pay_cnt + 5'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (qcnt != 3'd0) state_nxt = HDR;
      HDR:     if (xfer) state_nxt = PAY;
      PAY:     if (xfer && pay_cnt == out_len) state_nxt = TRL;
      TRL:     if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    pkt_valid = 1'b0;
    pkt_sop   = 1'b0;
    pkt_eop   = 1'b0;
    pkt_data  = '0;
    case (state)
      HDR: begin
        pkt_valid = 1'b1;
        pkt_sop   = 1'b1;
        pkt_data  = {8'hA5, 19'd0, out_len};
      end
      PAY: begin
        pkt_valid = 1'b1;
        pkt_data  = dmem[drd_ptr];
      end
      TRL: begin
        pkt_valid = 1'b1;
        pkt_eop   = 1'b1;
        pkt_data  = out_sum;
      end
      default: ;
    endcase
  end

endmodule
